// File: rtl/lsu_writeback.sv
// ---------------------------------------------------------------------------
// lsu_writeback
//   Writeback stage directly downstream of the load/store unit. It registers
//   the MEM-stage metadata and lines it up with the LSU load data, which
//   returns one cycle after issue. It drives the register-file write port and
//   the WB forwarding bus, and it keeps a retired-instruction counter.
//
//   The LSU read path keeps updating while the pipeline is stalled. For that
//   reason, load data is captured into a hold buffer on the first stall cycle.
//   The write then repeats with identical data for the rest of the stall.
//
// Ports
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   i_stall, i_flush    pipeline hold / kill of the instruction entering WB
//   i_mem_*             MEM-stage instruction metadata and ALU result
//   i_lsu_load_data     load data, valid in the cycle after the load is in MEM
//   o_wb_*              WB valid and register-file write port
//   o_fwd_*             forwarding bus (mirrors the write port)
//   o_retire_cnt        count of instructions retired from WB (wraps)
// ---------------------------------------------------------------------------
module lsu_writeback (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_mem_valid,
  input  logic        i_mem_is_load,
  input  logic        i_mem_rd_wren,
  input  logic [4:0]  i_mem_rd_addr,
  input  logic [31:0] i_mem_alu_result,
  input  logic [31:0] i_lsu_load_data,
  output logic        o_wb_valid,
  output logic        o_wb_rd_wren,
  output logic [4:0]  o_wb_rd_addr,
  output logic [31:0] o_wb_rd_data,
  output logic        o_fwd_valid,
  output logic [4:0]  o_fwd_rd_addr,
  output logic [31:0] o_fwd_data,
  output logic [31:0] o_retire_cnt
);

  logic        valid_q,     valid_d;
  logic        is_load_q,   is_load_d;
  logic        rd_wren_q,   rd_wren_d;
  logic [4:0]  rd_q,        rd_d;
  logic [31:0] alu_q,       alu_d;
  logic        hold_vld_q,  hold_vld_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  logic [31:0] sel_data;

  // Next-state logic for the stage registers, the hold buffer and the counter.
  always_comb begin
    // NOTE: each signal gets a default here first, so every path assigns it
    // and no latch is inferred.
    valid_d      = valid_q;
    is_load_d    = is_load_q;
    rd_wren_d    = rd_wren_q;
    rd_d         = rd_q;
    alu_d        = alu_q;
    hold_vld_d   = hold_vld_q;
    hold_data_d  = hold_data_q;

    if (i_flush) begin
      // A flush only needs to kill valid. The other fields are don't-care.
      valid_d = 1'b0;
    end else if (!i_stall) begin
      valid_d   = i_mem_valid;
      is_load_d = i_mem_is_load;
      rd_wren_d = i_mem_rd_wren;
      rd_d      = i_mem_rd_addr;
      alu_d     = i_mem_alu_result;
    end

    // Catch the load data on the first stall cycle only, then freeze it.
    if (i_flush || !i_stall) begin
      hold_vld_d = 1'b0;
    end else if (valid_q && is_load_q && !hold_vld_q) begin
      hold_vld_d  = 1'b1;
      hold_data_d = i_lsu_load_data;
    end

    // An instruction retires when it leaves WB, which happens on the first
    // unstalled edge. A flush on that same edge does not stop it retiring.
    retire_cnt_d = retire_cnt_q + {31'd0, (valid_q & ~i_stall)};
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops
  // read their _d value as it stood before the edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q      <= 1'b0;
      is_load_q    <= 1'b0;
      rd_wren_q    <= 1'b0;
      rd_q         <= 5'd0;
      alu_q        <= 32'd0;
      hold_vld_q   <= 1'b0;
      hold_data_q  <= 32'd0;
      retire_cnt_q <= 32'd0;
    end else begin
      valid_q      <= valid_d;
      is_load_q    <= is_load_d;
      rd_wren_q    <= rd_wren_d;
      rd_q         <= rd_d;
      alu_q        <= alu_d;
      hold_vld_q   <= hold_vld_d;
      hold_data_q  <= hold_data_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Write data select. Load data passes straight through until it has been
  // captured into the hold buffer.
  always_comb begin
    sel_data = alu_q;
    if (is_load_q) begin
      sel_data = hold_vld_q ? hold_data_q : i_lsu_load_data;
    end
  end

  assign o_wb_valid    = valid_q;
  assign o_wb_rd_wren  = valid_q & rd_wren_q & (rd_q != 5'd0);
  assign o_wb_rd_addr  = valid_q ? rd_q : 5'd0;
  assign o_wb_rd_data  = valid_q ? sel_data : 32'd0;
  assign o_fwd_valid   = o_wb_rd_wren;
  assign o_fwd_rd_addr = o_wb_rd_addr;
  assign o_fwd_data    = o_wb_rd_data;
  assign o_retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_lsu_writeback.sv
module tb_lsu_writeback;

  logic        i_clk;
  logic        i_rst;
  logic        i_stall;
  logic        i_flush;
  logic        i_mem_valid;
  logic        i_mem_is_load;
  logic        i_mem_rd_wren;
  logic [4:0]  i_mem_rd_addr;
  logic [31:0] i_mem_alu_result;
  logic [31:0] i_lsu_load_data;
  logic        o_wb_valid;
  logic        o_wb_rd_wren;
  logic [4:0]  o_wb_rd_addr;
  logic [31:0] o_wb_rd_data;
  logic        o_fwd_valid;
  logic [4:0]  o_fwd_rd_addr;
  logic [31:0] o_fwd_data;
  logic [31:0] o_retire_cnt;

  int          n_checks;
  int          n_pass;
  logic [31:0] exp_cnt;

  lsu_writeback dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_stall          (i_stall),
    .i_flush          (i_flush),
    .i_mem_valid      (i_mem_valid),
    .i_mem_is_load    (i_mem_is_load),
    .i_mem_rd_wren    (i_mem_rd_wren),
    .i_mem_rd_addr    (i_mem_rd_addr),
    .i_mem_alu_result (i_mem_alu_result),
    .i_lsu_load_data  (i_lsu_load_data),
    .o_wb_valid       (o_wb_valid),
    .o_wb_rd_wren     (o_wb_rd_wren),
    .o_wb_rd_addr     (o_wb_rd_addr),
    .o_wb_rd_data     (o_wb_rd_data),
    .o_fwd_valid      (o_fwd_valid),
    .o_fwd_rd_addr    (o_fwd_rd_addr),
    .o_fwd_data       (o_fwd_data),
    .o_retire_cnt     (o_retire_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Observed WB and forwarding outputs packed into one vector:
  // {valid, wren, addr, data, fwd_valid, fwd_addr, fwd_data}.
  logic [76:0] obs;
  assign obs = {o_wb_valid, o_wb_rd_wren, o_wb_rd_addr, o_wb_rd_data,
                o_fwd_valid, o_fwd_rd_addr, o_fwd_data};

  function automatic logic [76:0] exp_vec(input logic v, input logic we,
                                          input logic [4:0] addr,
                                          input logic [31:0] data);
    return {v, we, addr, data, we, addr, data};
  endfunction

  task automatic drive_mem(input logic v, input logic ld, input logic we,
                           input logic [4:0] rd, input logic [31:0] alu);
    i_mem_valid      = v;
    i_mem_is_load    = ld;
    i_mem_rd_wren    = we;
    i_mem_rd_addr    = rd;
    i_mem_alu_result = alu;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_stall = 1'b0;
    i_flush = 1'b0;
    i_lsu_load_data = 32'h0;
    drive_mem(1'b1, 1'b0, 1'b1, 5'd3, 32'h55);
    @(negedge i_clk); #1;
    n_checks++;
    if (obs !== 77'd0) $display("FAIL reset_outputs: got %h want 0", obs);
    else n_pass++;
    n_checks++;
    if (o_retire_cnt !== 32'd0) $display("FAIL reset_cnt: got %h want 0", o_retire_cnt);
    else n_pass++;
    drive_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    i_rst = 1'b0;
    @(negedge i_clk); #1;
    n_checks++;
    if (obs !== 77'd0) $display("FAIL post_reset_outputs: got %h want 0", obs);
    else n_pass++;
    exp_cnt = 32'd0;
  endtask

  task automatic test_basic_load();
    @(negedge i_clk);
    drive_mem(1'b1, 1'b1, 1'b1, 5'd5, 32'h0);
    @(negedge i_clk);
    drive_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    i_lsu_load_data = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (obs !== exp_vec(1'b1, 1'b1, 5'd5, 32'hDEADBEEF))
      $display("FAIL basic_load_wb: got %h want %h", obs, exp_vec(1'b1, 1'b1, 5'd5, 32'hDEADBEEF));
    else n_pass++;
    n_checks++;
    if (o_retire_cnt !== 32'd0) $display("FAIL basic_load_cnt_before: got %h want 0", o_retire_cnt);
    else n_pass++;
    exp_cnt = 32'd1;
    @(negedge i_clk); #1;
    n_checks++;
    if (obs !== 77'd0) $display("FAIL basic_load_idle: got %h want 0", obs);
    else n_pass++;
    n_checks++;
    if (o_retire_cnt !== exp_cnt) $display("FAIL basic_load_cnt_after: got %h want %h", o_retire_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_stalled_load();
    @(negedge i_clk);
    drive_mem(1'b1, 1'b1, 1'b1, 5'd5, 32'h0);
    // The WB cycle of the load is the first stall cycle. An ADD waits in MEM.
    @(negedge i_clk);
    drive_mem(1'b1, 1'b0, 1'b1, 5'd6, 32'h99);
    i_stall = 1'b1;
    i_lsu_load_data = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (obs !== exp_vec(1'b1, 1'b1, 5'd5, 32'hDEADBEEF))
      $display("FAIL stall_first_cycle: got %h want %h", obs, exp_vec(1'b1, 1'b1, 5'd5, 32'hDEADBEEF));
    else n_pass++;
    @(negedge i_clk);
    i_lsu_load_data = 32'h11111111;
    #1;
    n_checks++;
    if (obs !== exp_vec(1'b1, 1'b1, 5'd5, 32'hDEADBEEF))
      $display("FAIL stall_hold_1: got %h want %h", obs, exp_vec(1'b1, 1'b1, 5'd5, 32'hDEADBEEF));
    else n_pass++;
    @(negedge i_clk);
    i_lsu_load_data = 32'h22222222;
    #1;
    n_checks++;
    if (obs !== exp_vec(1'b1, 1'b1, 5'd5, 32'hDEADBEEF))
      $display("FAIL stall_hold_2: got %h want %h", obs, exp_vec(1'b1, 1'b1, 5'd5, 32'hDEADBEEF));
    else n_pass++;
    n_checks++;
    if (o_retire_cnt !== exp_cnt) $display("FAIL stall_no_retire: got %h want %h", o_retire_cnt, exp_cnt);
    else n_pass++;
    // Release: data is still held this cycle, and the load retires at the edge.
    @(negedge i_clk);
    i_stall = 1'b0;
    #1;
    n_checks++;
    if (o_wb_rd_data !== 32'hDEADBEEF) $display("FAIL stall_release_data: got %h want deadbeef", o_wb_rd_data);
    else n_pass++;
    exp_cnt = exp_cnt + 32'd1;
    @(negedge i_clk);
    drive_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    n_checks++;
    if (obs !== exp_vec(1'b1, 1'b1, 5'd6, 32'h99))
      $display("FAIL stall_next_instr: got %h want %h", obs, exp_vec(1'b1, 1'b1, 5'd6, 32'h99));
    else n_pass++;
    n_checks++;
    if (o_retire_cnt !== exp_cnt) $display("FAIL stall_retire_once: got %h want %h", o_retire_cnt, exp_cnt);
    else n_pass++;
    exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic test_x0_and_alu();
    @(negedge i_clk);
    drive_mem(1'b1, 1'b0, 1'b1, 5'd0, 32'h42);
    @(negedge i_clk);
    drive_mem(1'b1, 1'b0, 1'b1, 5'd7, 32'h42);
    #1;
    n_checks++;
    if (obs !== exp_vec(1'b1, 1'b0, 5'd0, 32'h42))
      $display("FAIL x0_suppressed: got %h want %h", obs, exp_vec(1'b1, 1'b0, 5'd0, 32'h42));
    else n_pass++;
    n_checks++;
    if (o_retire_cnt !== exp_cnt) $display("FAIL x0_cnt_before: got %h want %h", o_retire_cnt, exp_cnt);
    else n_pass++;
    exp_cnt = exp_cnt + 32'd1;
    @(negedge i_clk);
    drive_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    n_checks++;
    if (obs !== exp_vec(1'b1, 1'b1, 5'd7, 32'h42))
      $display("FAIL alu_x7: got %h want %h", obs, exp_vec(1'b1, 1'b1, 5'd7, 32'h42));
    else n_pass++;
    n_checks++;
    if (o_retire_cnt !== exp_cnt) $display("FAIL x0_counted: got %h want %h", o_retire_cnt, exp_cnt);
    else n_pass++;
    exp_cnt = exp_cnt + 32'd1;
    @(negedge i_clk); #1;
    n_checks++;
    if (o_retire_cnt !== exp_cnt) $display("FAIL alu_counted: got %h want %h", o_retire_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_flush();
    // Flush kills the incoming load, while the ADD already in WB still retires.
    @(negedge i_clk);
    drive_mem(1'b1, 1'b0, 1'b1, 5'd7, 32'h13);
    @(negedge i_clk);
    drive_mem(1'b1, 1'b1, 1'b1, 5'd9, 32'h0);
    i_flush = 1'b1;
    #1;
    n_checks++;
    if (obs !== exp_vec(1'b1, 1'b1, 5'd7, 32'h13))
      $display("FAIL flush_prev_wb: got %h want %h", obs, exp_vec(1'b1, 1'b1, 5'd7, 32'h13));
    else n_pass++;
    exp_cnt = exp_cnt + 32'd1;
    @(negedge i_clk);
    i_flush = 1'b0;
    drive_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    n_checks++;
    if (obs !== 77'd0) $display("FAIL flush_killed: got %h want 0", obs);
    else n_pass++;
    n_checks++;
    if (o_retire_cnt !== exp_cnt) $display("FAIL flush_cnt: got %h want %h", o_retire_cnt, exp_cnt);
    else n_pass++;
    // Flush during a stall drops the held load.
    @(negedge i_clk);
    drive_mem(1'b1, 1'b1, 1'b1, 5'd4, 32'h0);
    @(negedge i_clk);
    drive_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    i_stall = 1'b1;
    i_lsu_load_data = 32'hAAAA5555;
    #1;
    n_checks++;
    if (o_wb_rd_data !== 32'hAAAA5555) $display("FAIL flush_stall_pass: got %h want aaaa5555", o_wb_rd_data);
    else n_pass++;
    @(negedge i_clk);
    i_flush = 1'b1;
    i_lsu_load_data = 32'h0;
    #1;
    n_checks++;
    if (o_wb_rd_data !== 32'hAAAA5555) $display("FAIL flush_stall_held: got %h want aaaa5555", o_wb_rd_data);
    else n_pass++;
    @(negedge i_clk);
    i_stall = 1'b0;
    i_flush = 1'b0;
    drive_mem(1'b1, 1'b1, 1'b1, 5'd4, 32'h0);
    #1;
    n_checks++;
    if (obs !== 77'd0) $display("FAIL flush_stall_dropped: got %h want 0", obs);
    else n_pass++;
    n_checks++;
    if (o_retire_cnt !== exp_cnt) $display("FAIL flush_stall_cnt: got %h want %h", o_retire_cnt, exp_cnt);
    else n_pass++;
    n_checks++;
    if (dut.hold_vld_q !== 1'b0) $display("FAIL flush_stall_hold_vld: got %b want 0", dut.hold_vld_q);
    else n_pass++;
    // The next load must use live data, not the dropped hold buffer.
    @(negedge i_clk);
    drive_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    i_lsu_load_data = 32'h12345678;
    #1;
    n_checks++;
    if (obs !== exp_vec(1'b1, 1'b1, 5'd4, 32'h12345678))
      $display("FAIL flush_next_load: got %h want %h", obs, exp_vec(1'b1, 1'b1, 5'd4, 32'h12345678));
    else n_pass++;
    exp_cnt = exp_cnt + 32'd1;
    @(negedge i_clk); #1;
    n_checks++;
    if (o_retire_cnt !== exp_cnt) $display("FAIL flush_next_cnt: got %h want %h", o_retire_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_counter_wrap();
    @(negedge i_clk);
    force dut.retire_cnt_q = 32'hFFFF_FFFE;
    drive_mem(1'b1, 1'b0, 1'b1, 5'd1, 32'h1);
    #1;
    release dut.retire_cnt_q;
    exp_cnt = 32'hFFFF_FFFE;
    @(negedge i_clk);
    drive_mem(1'b1, 1'b0, 1'b1, 5'd2, 32'h2);
    #1;
    n_checks++;
    if (o_retire_cnt !== exp_cnt) $display("FAIL wrap_preload: got %h want %h", o_retire_cnt, exp_cnt);
    else n_pass++;
    exp_cnt = exp_cnt + 32'd1;
    @(negedge i_clk);
    drive_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    n_checks++;
    if (o_retire_cnt !== 32'hFFFF_FFFF) $display("FAIL wrap_max: got %h want ffffffff", o_retire_cnt);
    else n_pass++;
    exp_cnt = exp_cnt + 32'd1;
    @(negedge i_clk); #1;
    n_checks++;
    if (o_retire_cnt !== 32'd0) $display("FAIL wrap_zero: got %h want 0", o_retire_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    @(negedge i_clk);
    drive_mem(1'b1, 1'b1, 1'b1, 5'd8, 32'h0);
    @(negedge i_clk);
    drive_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    i_stall = 1'b1;
    i_lsu_load_data = 32'hCAFEF00D;
    @(negedge i_clk);
    i_lsu_load_data = 32'h0;
    #1;
    n_checks++;
    if (obs !== exp_vec(1'b1, 1'b1, 5'd8, 32'hCAFEF00D))
      $display("FAIL rst_stall_held: got %h want %h", obs, exp_vec(1'b1, 1'b1, 5'd8, 32'hCAFEF00D));
    else n_pass++;
    i_rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== 77'd0) $display("FAIL rst_async_outputs: got %h want 0", obs);
    else n_pass++;
    n_checks++;
    if (o_retire_cnt !== 32'd0) $display("FAIL rst_async_cnt: got %h want 0", o_retire_cnt);
    else n_pass++;
    n_checks++;
    if (dut.hold_vld_q !== 1'b0) $display("FAIL rst_hold_vld: got %b want 0", dut.hold_vld_q);
    else n_pass++;
    exp_cnt = 32'd0;
    @(negedge i_clk);
    i_rst = 1'b0;
    i_stall = 1'b0;
    drive_mem(1'b1, 1'b0, 1'b1, 5'd3, 32'h5);
    @(negedge i_clk);
    drive_mem(1'b1, 1'b1, 1'b1, 5'd3, 32'h0);
    #1;
    n_checks++;
    if (obs !== exp_vec(1'b1, 1'b1, 5'd3, 32'h5))
      $display("FAIL rst_new_add: got %h want %h", obs, exp_vec(1'b1, 1'b1, 5'd3, 32'h5));
    else n_pass++;
    exp_cnt = exp_cnt + 32'd1;
    @(negedge i_clk);
    drive_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    i_lsu_load_data = 32'h5;
    #1;
    n_checks++;
    if (obs !== exp_vec(1'b1, 1'b1, 5'd3, 32'h5))
      $display("FAIL rst_new_load: got %h want %h", obs, exp_vec(1'b1, 1'b1, 5'd3, 32'h5));
    else n_pass++;
    exp_cnt = exp_cnt + 32'd1;
    @(negedge i_clk); #1;
    n_checks++;
    if (o_retire_cnt !== exp_cnt) $display("FAIL rst_cnt_after: got %h want %h", o_retire_cnt, exp_cnt);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_cnt  = 32'd0;
    test_reset();
    test_basic_load();
    test_stalled_load();
    test_x0_and_alu();
    test_flush();
    test_counter_wrap();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
